// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, EX-side
// mispredict detection and saturating resolve/mispredict performance counters.
module branch_predictor #(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  input  logic              flush_tbl,
  output logic              mispredict,
  output logic [31:0]       recover_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [CNT_W-1:0] br_q, br_d, mp_q, mp_d;

  logic [IDX_W-1:0] if_idx, u_idx;
  logic [TAG_W-1:0] if_tag, u_tag;
  logic             ctl, taken_eff, u_hit, wr_en;
  logic [1:0]       ctr_d;
  logic [31:0]      tgt_d;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign u_idx  = upd_pc[IDX_W+1:2];
  assign u_tag  = upd_pc[PC_W-1:IDX_W+2];

  // Lookup reads registered state only; no bypass from a same-cycle update.
  always_comb begin
    pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = pred_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? tgt_q[if_idx] : 32'(if_pc) + 32'd4;
  end

  always_comb begin
    ctl        = upd_valid && (upd_is_branch || upd_is_jump);
    taken_eff  = upd_taken || upd_is_jump;
    mispredict = ctl && ((taken_eff != upd_pred_taken) ||
                         (taken_eff && (upd_target != upd_pred_target)));
    recover_pc = '0;
    if (ctl) recover_pc = taken_eff ? upd_target : 32'(upd_pc) + 32'd4;
  end

  // Jump takes precedence over branch when both flags are set.
  always_comb begin
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    wr_en = 1'b0;
    ctr_d = ctr_q[u_idx];
    tgt_d = tgt_q[u_idx];
    if (ctl) begin
      if (upd_is_jump) begin
        wr_en = 1'b1;
        ctr_d = 2'b11;
        tgt_d = upd_target;
      end else if (u_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          tgt_d = upd_target;
          if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d = ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        wr_en = 1'b1;
        ctr_d = 2'b10;
        tgt_d = upd_target;
      end
    end
  end

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (ctl && (br_q != '1))        br_d = br_q + CNT_W'(1);
    if (mispredict && (mp_q != '1)) mp_d = mp_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (flush_tbl) begin
        for (int unsigned i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (wr_en) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= tgt_d;
        ctr_q[u_idx]   <= ctr_d;
      end
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign branch_cnt  = br_q;
  assign mispred_cnt = mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector scoreboard bench for branch_predictor; a second instance
// with 4-bit counters exercises counter saturation on the same stimulus.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  if_pc = '0;
  logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0, upd_pred_taken = 1'b0, flush_tbl = 1'b0;
  logic [8:0]  upd_pc = '0;
  logic [31:0] upd_target = '0, upd_pred_target = '0;

  logic        hit, tk, mp, s_hit, s_tk, s_mp;
  logic [31:0] tgt, rpc, s_tgt, s_rpc;
  logic [15:0] br_cnt, mp_cnt;
  logic [3:0]  s_br_cnt, s_mp_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_hit(hit), .pred_taken(tk), .pred_target(tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_tbl(flush_tbl), .mispredict(mp), .recover_pc(rpc),
    .branch_cnt(br_cnt), .mispred_cnt(mp_cnt)
  );

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_hit(s_hit), .pred_taken(s_tk), .pred_target(s_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_tbl(flush_tbl), .mispredict(s_mp), .recover_pc(s_rpc),
    .branch_cnt(s_br_cnt), .mispred_cnt(s_mp_cnt)
  );

  typedef struct {
    string       name;
    logic        hit, tk, mp;
    logic [31:0] tgt, rpc;
    int unsigned br, mpc;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0, errors = 0;
  int unsigned exp_br = 0, exp_mp = 0;

  function automatic int unsigned sat(int unsigned v, int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void cmp(string nm, string f, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, want);
    end
  endfunction

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "pred_hit", 32'(hit), 32'(e.hit));
        cmp(e.name, "pred_taken", 32'(tk), 32'(e.tk));
        cmp(e.name, "pred_target", tgt, e.tgt);
        cmp(e.name, "mispredict", 32'(mp), 32'(e.mp));
        cmp(e.name, "recover_pc", rpc, e.rpc);
        cmp(e.name, "branch_cnt", 32'(br_cnt), sat(e.br, 16'hFFFF));
        cmp(e.name, "mispred_cnt", 32'(mp_cnt), sat(e.mpc, 16'hFFFF));
        cmp(e.name, "sat_branch_cnt", 32'(s_br_cnt), sat(e.br, 15));
        cmp(e.name, "sat_mispred_cnt", 32'(s_mp_cnt), sat(e.mpc, 15));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(logic [8:0] pc);
    if_pc = pc;
    upd_valid = 1'b0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_pred_taken = 1'b0; flush_tbl = 1'b0;
    upd_pc = '0; upd_target = '0; upd_pred_target = '0;
  endtask

  task automatic upd(logic [8:0] pc, logic br, logic j, logic t,
                     logic [31:0] tg, logic pt, logic [31:0] ptg);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = j;
    upd_taken = t; upd_target = tg; upd_pred_taken = pt; upd_pred_target = ptg;
  endtask

  // Push expected outputs for this cycle, then advance the counter model.
  task automatic want(string nm, logic h, logic t, logic [31:0] tg,
                      logic m, logic [31:0] r);
    exp_t e;
    e.name = nm; e.hit = h; e.tk = t; e.tgt = tg; e.mp = m; e.rpc = r;
    e.br = exp_br; e.mpc = exp_mp;
    q.push_back(e);
    if (rst_n) begin
      if (upd_valid && (upd_is_branch || upd_is_jump)) exp_br++;
      if (m) exp_mp++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); idle(9'h040);
    want("reset", 0, 0, 32'h044, 0, 0);
    tick(); rst_n = 1'b1;

    tick(); idle(9'h040); upd(9'h040, 1, 0, 1, 32'h020, 0, 32'h044);
    want("alloc_taken", 0, 0, 32'h044, 1, 32'h020);
    tick(); idle(9'h040);
    want("hit_after_alloc", 1, 1, 32'h020, 0, 0);
    tick(); idle(9'h040); upd(9'h040, 1, 0, 0, 32'h020, 1, 32'h020);
    want("nt_mispred", 1, 1, 32'h020, 1, 32'h044);
    tick(); idle(9'h040); upd(9'h040, 1, 0, 0, 32'h020, 0, 32'h044);
    want("nt_ok", 1, 0, 32'h044, 0, 32'h044);
    tick(); idle(9'h040);
    want("ctr00_lookup", 1, 0, 32'h044, 0, 0);
    tick(); idle(9'h040); upd(9'h040, 1, 0, 1, 32'h020, 1, 32'h020);
    want("tk_wrong_dir_ok_tgt", 1, 0, 32'h044, 0, 32'h020);
    tick(); idle(9'h040); upd(9'h040, 1, 0, 1, 32'h020, 0, 32'h044);
    want("ctr01_to_10", 1, 0, 32'h044, 1, 32'h020);
    tick(); idle(9'h040);
    want("ctr10_lookup", 1, 1, 32'h020, 0, 0);
    tick(); idle(9'h040); upd(9'h040, 1, 0, 1, 32'h020, 1, 32'h020);
    want("ctr10_to_11", 1, 1, 32'h020, 0, 32'h020);
    tick(); idle(9'h040); upd(9'h040, 1, 0, 1, 32'h020, 1, 32'h020);
    want("ctr11_hold", 1, 1, 32'h020, 0, 32'h020);
    tick(); idle(9'h040); upd(9'h040, 1, 0, 0, 32'h020, 1, 32'h020);
    want("ctr11_dec", 1, 1, 32'h020, 1, 32'h044);
    tick(); idle(9'h040);
    want("ctr10_no_wrap", 1, 1, 32'h020, 0, 0);
    tick(); idle(9'h040); upd(9'h0C0, 1, 0, 0, 32'h300, 0, 32'h0C4);
    want("miss_nt_noalloc", 1, 1, 32'h020, 0, 32'h0C4);
    tick(); idle(9'h040); upd(9'h080, 0, 1, 0, 32'h100, 0, 32'h084);
    want("alias_jump", 1, 1, 32'h020, 1, 32'h100);
    tick(); idle(9'h040);
    want("alias_evicted", 0, 0, 32'h044, 0, 0);
    tick(); idle(9'h080);
    want("alias_hit", 1, 1, 32'h100, 0, 0);
    tick(); idle(9'h080); upd(9'h080, 0, 1, 0, 32'h104, 1, 32'h100);
    want("jump_bad_tgt", 1, 1, 32'h100, 1, 32'h104);
    tick(); idle(9'h080);
    want("jump_retrained", 1, 1, 32'h104, 0, 0);
    tick(); idle(9'h044); upd(9'h044, 1, 1, 0, 32'h200, 0, 32'h048);
    want("br_and_jump", 0, 0, 32'h048, 1, 32'h200);
    tick(); idle(9'h044);
    want("br_and_jump_alloc", 1, 1, 32'h200, 0, 0);
    tick(); idle(9'h048); upd(9'h048, 1, 0, 1, 32'h300, 0, 32'h04C);
    flush_tbl = 1'b1;
    want("flush_with_upd", 0, 0, 32'h04C, 1, 32'h300);
    tick(); idle(9'h048);
    want("flush_wins", 0, 0, 32'h04C, 0, 0);
    tick(); idle(9'h080);
    want("flush_cleared", 0, 0, 32'h084, 0, 0);

    for (int i = 0; i < 20; i++) begin
      tick(); idle(9'h000); upd(9'h0C0, 0, 1, 0, 32'h010, 0, 32'h0C4);
      want($sformatf("sat_mp%0d", i), 0, 0, 32'h004, 1, 32'h010);
    end
    tick(); idle(9'h0C0);
    want("sat_hold", 1, 1, 32'h010, 0, 0);

    tick(); idle(9'h0C0); rst_n = 1'b0;
    exp_br = 0; exp_mp = 0;
    want("async_reset", 0, 0, 32'h0C4, 0, 0);
    tick(); rst_n = 1'b1;

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters. It is the parametrised successor to the combinational branch-resolution logic and sits between IF and EX. IF gets a predicted next PC in the same cycle as the fetch address. EX resolves each control-flow instruction and feeds the outcome back, which trains the table and raises a recovery redirect on a mispredict. Two saturating performance counters track resolved branches and mispredicts.

## Interface
- PC_W, 9, width of instruction PC; must satisfy PC_W > IDX_W+2
- ENTRIES, 16, BTB entries, power of two ≥ 2; IDX_W = $clog2(ENTRIES), TAG_W = PC_W-IDX_W-2
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_pc  in  PC_W  fetch address being looked up
- pred_hit  out  1  valid entry with matching tag for if_pc
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- upd_valid  in  1  EX has a resolved instruction this cycle
- upd_pc  in  PC_W  PC of resolved instruction
- upd_is_branch  in  1  conditional branch
- upd_is_jump  in  1  JAL/JALR (always taken)
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target (PC+Imm or Reg1+Imm)
- upd_pred_taken  in  1  direction that was predicted for it (pipelined from IF)
- upd_pred_target  in  32  target that was predicted for it
- flush_tbl  in  1  synchronous invalidate of whole table
- mispredict  out  1  redirect required this cycle
- recover_pc  out  32  correct next PC when mispredict=1
- branch_cnt  out  CNT_W  resolved control-flow instructions
- mispred_cnt  out  CNT_W  mispredicts

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Each entry holds valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational from registered table):
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[1].
  - pred_target = pred_taken ? target : zero-extended if_pc + 4.
- Resolve (ctl = upd_valid && (upd_is_branch || upd_is_jump)); taken_eff = upd_taken || upd_is_jump:
  - mispredict = ctl && (taken_eff != upd_pred_taken || (taken_eff && upd_target != upd_pred_target)).
  - recover_pc = taken_eff ? upd_target : zero-extended upd_pc + 4.
  - If ctl=0, both outputs are 0.
- Training on ctl, at the clock edge:
  - Hit, conditional branch: ctr saturating +1 if taken, −1 if not taken (floor 00, ceiling 11). Target is overwritten only when taken.
  - Hit, jump: ctr ← 11, target ← upd_target.
  - Miss, taken or jump: allocate, overwriting any old occupant (direct-mapped). Set valid=1, tag, target, ctr ← 11 for a jump, 10 for a taken branch.
  - Miss, not-taken branch: no change.
- Counters: branch_cnt +1 on ctl; mispred_cnt +1 on mispredict. Both saturate at all-ones and do not wrap.
- flush_tbl clears every valid bit; ctr/target/tag are don't-care. Counters are not cleared.
- If both upd_is_branch and upd_is_jump are set, treat the instruction as a jump.

## Timing
- Reset (rst_n=0, asynchronous): all valid=0; all ctr=01; branch_cnt = mispred_cnt = 0. Outputs then read pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict=0, recover_pc=0.
- Lookup latency 0 cycles: combinational from table state. mispredict/recover_pc are combinational, 0 cycles.
- A training write becomes visible to lookup on the cycle after its edge. There is no same-cycle bypass: an update and a lookup to the same index in one cycle return the old entry.
- flush_tbl and an update in the same cycle: flush wins and the entry stays invalid. Counters still count that update.
- rst_n asserted mid-operation: state clears immediately regardless of clk. Release is synchronous to the next edge under normal reset-release rules.

## Test plan
- Reset, then if_pc=0x040 → pred_hit=0, pred_taken=0, pred_target=0x044; both counters 0.
- Taken branch at upd_pc=0x040, target 0x020, pred_taken=0 → mispredict=1, recover_pc=0x020. Next cycle, if_pc=0x040 → hit, pred_taken=1, pred_target=0x020.
- Same branch not taken twice → ctr 10→01→00. Third lookup gives pred_taken=0, pred_target=0x044. A not-taken resolve that was predicted taken gives mispredict=1, recover_pc=0x044.
- ENTRIES=16: allocate 0x040, then a jump at aliasing PC 0x080 → 0x040 lookup misses, 0x080 hits with ctr=11.
- Jump predicted taken to 0x100, actual target 0x104 → mispredict=1, recover_pc=0x104; target retrained.
- Set CNT_W=4 and drive 20 mispredicts → branch_cnt = mispred_cnt = 15, holding. Then flush_tbl together with an update → entry invalid next cycle.
